video_pattern_gen: RTL and testbench

VIDEO_PATTERN_GEN -- requirements
Module: video_pattern_gen

---
 rtl/video_pkg.sv | 30 +++
 rtl/video_timing_ctr.sv | 59 +++++
 rtl/video_pattern_gen.sv | 201 ++++++++++++++++++++
 tb/tb_video_pattern_gen.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared definitions for the video pattern generator: pattern encodings,
// the colour-bar table and the default 640x480 timing constants.
package video_pkg;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_RAMP  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_FB    = 2'd3
  } pattern_e;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // {r,g,b} full-scale flags; index 0 is the leftmost bar.
  localparam logic [0:7][2:0] BAR_TABLE = '{
    3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
  };

  function automatic logic [2:0] bar_color(input logic [2:0] idx);
    return BAR_TABLE[idx];
  endfunction

endpackage

// File: rtl/video_timing_ctr.sv
// Raster counters with active-area and sync-pulse decode; the counters sit
// at (0,0) while disabled so a restart always begins on a fresh frame.
module video_timing_ctr #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_enable,
  output logic [HW-1:0] o_h_cnt,
  output logic [VW-1:0] o_v_cnt,
  output logic          o_active,
  output logic          o_hs_pulse,
  output logic          o_vs_pulse,
  output logic          o_first
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic          w_h_last;
  logic          w_v_last;

  assign w_h_last = (r_h == HW'(H_TOT - 1));
  assign w_v_last = (r_v == VW'(V_TOT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_h <= '0;
      r_v <= '0;
    end else if (!i_enable) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_h_last) begin
      r_h <= '0;
      r_v <= w_v_last ? '0 : r_v + VW'(1);
    end else begin
      r_h <= r_h + HW'(1);
    end
  end

  assign o_h_cnt    = r_h;
  assign o_v_cnt    = r_v;
  assign o_active   = (r_h < HW'(H_ACTIVE)) && (r_v < VW'(V_ACTIVE));
  assign o_hs_pulse = (r_h >= HW'(H_ACTIVE + H_FP)) && (r_h < HW'(H_ACTIVE + H_FP + H_SYNC));
  assign o_vs_pulse = (r_v >= VW'(V_ACTIVE + V_FP)) && (r_v < VW'(V_ACTIVE + V_FP + V_SYNC));
  assign o_first    = (r_h == '0) && (r_v == '0);

endmodule

// File: rtl/video_pattern_gen.sv
// Test-pattern video source: bars, grey ramp, checkerboard and an optional
// framebuffer pattern enabled by defining VIDEO_PATTERN_GEN_FB_EN.
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int COLOR_W  = 8
`ifdef VIDEO_PATTERN_GEN_FB_EN
  ,
  parameter int FB_W     = 64,
  parameter int FB_H     = 32
`endif
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [1:0]         pattern_sel,
  output logic               vid_de,
  output logic               vid_hs,
  output logic               vid_vs,
  output logic [COLOR_W-1:0] vid_r,
  output logic [COLOR_W-1:0] vid_g,
  output logic [COLOR_W-1:0] vid_b,
  output logic               frame_start
`ifdef VIDEO_PATTERN_GEN_FB_EN
  ,
  output logic                    fb_req,
  output logic [$clog2(FB_W)-1:0] fb_x,
  output logic [$clog2(FB_H)-1:0] fb_y,
  input  logic                    fb_pix
`endif
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);
  localparam int RW    = HW + COLOR_W;
  localparam int BAR_W = H_ACTIVE / 8;

  if ((H_ACTIVE % 8) != 0 || H_ACTIVE < 8 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 || COLOR_W < 1) begin : g_param_check
    $error("video_pattern_gen: H_ACTIVE must be a multiple of 8 and all widths >= 1");
  end

  logic [HW-1:0] w_h_cnt;
  logic [VW-1:0] w_v_cnt;
  logic          w_active;
  logic          w_hs_pulse;
  logic          w_vs_pulse;
  logic          w_first;

  video_timing_ctr #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HW(HW), .VW(VW)
  ) u_timing (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_enable  (enable),
    .o_h_cnt   (w_h_cnt),
    .o_v_cnt   (w_v_cnt),
    .o_active  (w_active),
    .o_hs_pulse(w_hs_pulse),
    .o_vs_pulse(w_vs_pulse),
    .o_first   (w_first)
  );

  // The selection is used directly at pixel (0,0) so the whole frame, its
  // first pixel included, shows the newly sampled pattern.
  pattern_e r_pat;
  pattern_e w_pat;
  assign w_pat = w_first ? pattern_e'(pattern_sel) : r_pat;

  logic [HW-1:0]      w_bar_q;
  logic [2:0]         w_bar_idx;
  logic [2:0]         w_bar_rgb;
  logic [COLOR_W-1:0] w_grey;
  logic               w_check;

  assign w_bar_q   = w_h_cnt / HW'(BAR_W);
  assign w_bar_idx = (w_bar_q > HW'(7)) ? 3'd7 : w_bar_q[2:0];
  assign w_bar_rgb = bar_color(w_bar_idx);
  assign w_grey    = COLOR_W'({w_h_cnt, {COLOR_W{1'b0}}} / RW'(H_ACTIVE));
  assign w_check   = 1'(w_h_cnt >> 5) ^ 1'(w_v_cnt >> 5);

  logic [COLOR_W-1:0] w_r, w_g, w_b;

  always_comb begin
    w_r = '0;
    w_g = '0;
    w_b = '0;
    case (w_pat)
      PAT_BARS: begin
        w_r = {COLOR_W{w_bar_rgb[2]}};
        w_g = {COLOR_W{w_bar_rgb[1]}};
        w_b = {COLOR_W{w_bar_rgb[0]}};
      end
      PAT_RAMP: begin
        w_r = w_grey;
        w_g = w_grey;
        w_b = w_grey;
      end
      PAT_CHECK: begin
        w_r = {COLOR_W{w_check}};
        w_g = {COLOR_W{w_check}};
        w_b = {COLOR_W{w_check}};
      end
      default: begin
      end
    endcase
  end

  logic w_pix_on;
  logic w_fb_cycle;
  assign w_pix_on   = enable & w_active;
  assign w_fb_cycle = w_pix_on & (w_pat == PAT_FB);

  logic               r1_de, r1_hs, r1_vs, r1_fs, r1_fb;
  logic [COLOR_W-1:0] r1_r, r1_g, r1_b;
  logic               r2_de, r2_hs, r2_vs, r2_fs;
  logic [COLOR_W-1:0] r2_r, r2_g, r2_b;
  logic [COLOR_W-1:0] w_s2_r, w_s2_g, w_s2_b;

`ifdef VIDEO_PATTERN_GEN_FB_EN
  localparam int FXW = $clog2(FB_W);
  localparam int FYW = $clog2(FB_H);
  localparam int FMX = HW + FXW + 1;
  localparam int FMY = VW + FYW + 1;

  // Memory answers one cycle after the request, landing beside stage 1.
  assign fb_req = w_fb_cycle;
  assign fb_x   = FXW'((FMX'(w_h_cnt) * FMX'(FB_W)) / FMX'(H_ACTIVE));
  assign fb_y   = FYW'((FMY'(w_v_cnt) * FMY'(FB_H)) / FMY'(V_ACTIVE));
  assign w_s2_r = r1_fb ? {COLOR_W{fb_pix}} : r1_r;
  assign w_s2_g = r1_fb ? {COLOR_W{fb_pix}} : r1_g;
  assign w_s2_b = r1_fb ? {COLOR_W{fb_pix}} : r1_b;
`else
  assign w_s2_r = r1_r;
  assign w_s2_g = r1_g;
  assign w_s2_b = r1_b;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pat <= PAT_BARS;
      r1_de <= 1'b0;
      r1_hs <= ~HS_POL;
      r1_vs <= ~VS_POL;
      r1_fs <= 1'b0;
      r1_fb <= 1'b0;
      r1_r  <= '0;
      r1_g  <= '0;
      r1_b  <= '0;
      r2_de <= 1'b0;
      r2_hs <= ~HS_POL;
      r2_vs <= ~VS_POL;
      r2_fs <= 1'b0;
      r2_r  <= '0;
      r2_g  <= '0;
      r2_b  <= '0;
    end else begin
      if (enable && w_first) begin
        r_pat <= pattern_e'(pattern_sel);
      end
      r1_de <= w_pix_on;
      r1_hs <= (enable && w_hs_pulse) ? HS_POL : ~HS_POL;
      r1_vs <= (enable && w_vs_pulse) ? VS_POL : ~VS_POL;
      r1_fs <= enable & w_first;
      r1_fb <= w_fb_cycle;
      r1_r  <= w_pix_on ? w_r : '0;
      r1_g  <= w_pix_on ? w_g : '0;
      r1_b  <= w_pix_on ? w_b : '0;
      r2_de <= r1_de;
      r2_hs <= r1_hs;
      r2_vs <= r1_vs;
      r2_fs <= r1_fs;
      r2_r  <= w_s2_r;
      r2_g  <= w_s2_g;
      r2_b  <= w_s2_b;
    end
  end

  assign vid_de      = r2_de;
  assign vid_hs      = r2_hs;
  assign vid_vs      = r2_vs;
  assign vid_r       = r2_r;
  assign vid_g       = r2_g;
  assign vid_b       = r2_b;
  assign frame_start = r2_fs;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen: a default-timing instance for first-line
// timing literals and a reduced-timing instance checked against a raster model.
module tb_video_pattern_gen;

  // Reduced raster so several whole frames fit in a short run.
  localparam int HA  = 64;
  localparam int HFP = 4;
  localparam int HSW = 8;
  localparam int HBP = 4;
  localparam int VA  = 48;
  localparam int VFP = 2;
  localparam int VSW = 3;
  localparam int VBP = 3;
  localparam int HT  = HA + HFP + HSW + HBP;
  localparam int VT  = VA + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;
  localparam int FBW = 32;
  localparam int FBH = 24;

  localparam logic [23:0] BARS [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [23:0] rgb;
  } exp_t;

  localparam exp_t RST = '{de: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0, rgb: 24'h0};

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] pattern_sel = 2'd0;
  logic       en_def = 1'b1;
  logic [1:0] sel_def = 2'd0;

  logic       de, hs, vs, fs;
  logic [7:0] r, g, b;
  logic       d_de, d_hs, d_vs, d_fs;
  logic [7:0] d_r, d_g, d_b;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

`ifdef VIDEO_PATTERN_GEN_FB_EN
  logic       fb_req, d_fb_req;
  logic [4:0] fb_x, fb_y;
  logic [5:0] d_fb_x;
  logic [4:0] d_fb_y;
  logic       fb_pix = 1'b0;
  logic       d_fb_pix = 1'b0;

  // Framebuffer holding a single lit texel at (5,3), one cycle read latency.
  always @(posedge clk) fb_pix <= fb_req && (fb_x == 5'd5) && (fb_y == 5'd3);
`endif

  video_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(8)
`ifdef VIDEO_PATTERN_GEN_FB_EN
    , .FB_W(FBW), .FB_H(FBH)
`endif
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .pattern_sel(pattern_sel),
    .vid_de(de), .vid_hs(hs), .vid_vs(vs), .vid_r(r), .vid_g(g), .vid_b(b),
    .frame_start(fs)
`ifdef VIDEO_PATTERN_GEN_FB_EN
    , .fb_req(fb_req), .fb_x(fb_x), .fb_y(fb_y), .fb_pix(fb_pix)
`endif
  );

  video_pattern_gen u_dut_def (
    .clk(clk), .reset_n(reset_n), .enable(en_def), .pattern_sel(sel_def),
    .vid_de(d_de), .vid_hs(d_hs), .vid_vs(d_vs), .vid_r(d_r), .vid_g(d_g), .vid_b(d_b),
    .frame_start(d_fs)
`ifdef VIDEO_PATTERN_GEN_FB_EN
    , .fb_req(d_fb_req), .fb_x(d_fb_x), .fb_y(d_fb_y), .fb_pix(d_fb_pix)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Colour of pixel (x,y) of the reduced raster for a given pattern.
  function automatic logic [23:0] pixel_rgb(input int x, input int y, input logic [1:0] pat);
    int         bi;
    logic [7:0] gv;
    case (pat)
      2'd0: begin
        bi = x / (HA / 8);
        if (bi > 7) bi = 7;
        return BARS[bi];
      end
      2'd1: begin
        gv = 8'((x * 256) / HA);
        return {gv, gv, gv};
      end
      2'd2: return ((((x >> 5) ^ (y >> 5)) & 1) == 1) ? 24'hFFFFFF : 24'h0;
      default: begin
`ifdef VIDEO_PATTERN_GEN_FB_EN
        return (((x * FBW) / HA == 5) && ((y * FBH) / VA == 3)) ? 24'hFFFFFF : 24'h0;
`else
        return 24'h0;
`endif
      end
    endcase
  endfunction

  // Expected outputs for the t-th enabled cycle since the raster (re)started.
  function automatic exp_t model_pixel(input int t, input logic [1:0] pat);
    int   h, v;
    exp_t e;
    h = t % HT;
    v = (t / HT) % VT;
    e.de  = (h < HA) && (v < VA);
    e.hs  = !((h >= HA + HFP) && (h < HA + HFP + HSW));
    e.vs  = !((v >= VA + VFP) && (v < VA + VFP + VSW));
    e.fs  = (h == 0) && (v == 0);
    e.rgb = e.de ? pixel_rgb(h, v, pat) : 24'h0;
    return e;
  endfunction

  int         m_t = 0;
  logic [1:0] m_pat = 2'd0;
  logic [1:0] m_use;
  exp_t       p1 = RST;
  exp_t       p2 = RST;

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_t   = 0;
        m_pat = 2'd0;
        p1    = RST;
        p2    = RST;
      end else begin
        p2 = p1;
        if (enable) begin
          m_use = ((m_t % FRAME) == 0) ? pattern_sel : m_pat;
          m_pat = m_use;
          p1    = model_pixel(m_t, m_use);
          m_t   = m_t + 1;
        end else begin
          m_t = 0;
          p1  = RST;
        end
      end
    end
  end

  exp_t act;
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        act = '{de: de, hs: hs, vs: vs, fs: fs, rgb: {r, g, b}};
        n_checks++;
        if (act !== p2) begin
          n_fails++;
          $display("FAIL model_cmp t=%0d: got de%b hs%b vs%b fs%b rgb %06h, expected de%b hs%b vs%b fs%b rgb %06h",
                   m_t, act.de, act.hs, act.vs, act.fs, act.rgb, p2.de, p2.hs, p2.vs, p2.fs, p2.rgb);
        end
      end
    end
  end

  // First line of the default 640x480 instance, cycle 0 being the (0,0) counter cycle.
  initial begin
    @(posedge reset_n);
    for (int c = 1; c <= 800; c++) begin
      @(negedge clk);
      chk("def_frame_start", 32'(d_fs), 32'(c == 2));
      chk("def_de", 32'(d_de), 32'((c >= 2) && (c <= 641)));
      chk("def_hs", 32'(d_hs), 32'(!((c >= 658) && (c <= 753))));
      chk("def_vs", 32'(d_vs), 32'd1);
      if (c == 2)   chk("def_rgb_x0",   32'({d_r, d_g, d_b}), 32'hFFFFFF);
      if (c == 82)  chk("def_rgb_x80",  32'({d_r, d_g, d_b}), 32'hFFFF00);
      if (c == 641) chk("def_rgb_x639", 32'({d_r, d_g, d_b}), 32'h000000);
    end
  end

  task automatic wait_fs(input string name, input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fs && n < budget);
    if (!fs) begin
      n_checks++;
      n_fails++;
      $display("FAIL %s: no frame_start within %0d cycles", name, budget);
    end
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_de"}, 32'(de), 32'd0);
    chk({name, "_hs"}, 32'(hs), 32'd1);
    chk({name, "_vs"}, 32'(vs), 32'd1);
    chk({name, "_fs"}, 32'(fs), 32'd0);
    chk({name, "_rgb"}, 32'({r, g, b}), 32'd0);
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  int n, vs_low;

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset_small");
    chk("reset_def_de", 32'(d_de), 32'd0);
    chk("reset_def_hs", 32'(d_hs), 32'd1);
    chk("reset_def_vs", 32'(d_vs), 32'd1);
    chk("reset_def_fs", 32'(d_fs), 32'd0);
    chk("reset_def_rgb", 32'({d_r, d_g, d_b}), 32'd0);

    enable = 1'b1;
    #1 reset_n = 1'b1;
    wait_fs("release_fs", 10, n);
    chk("release_fs_latency", 32'(n), 32'd2);

    // Switch to checkerboard around line 20: this frame must stay bars.
    repeat (20 * HT + 37) @(negedge clk);
    pattern_sel = 2'd2;
    wait_fs("frame1_fs", FRAME + 100, n);
    chk("check_px_0_0", 32'({r, g, b}), 32'h000000);
    n = 0;
    vs_low = 0;
    do begin
      @(negedge clk);
      n++;
      if (!vs) vs_low++;
      if (n == 32) chk("check_px_32_0", 32'({r, g, b}), 32'hFFFFFF);
    end while (!fs && n < FRAME + 100);
    chk("frame_period", 32'(n), 32'(FRAME));
    chk("vs_low_cycles", 32'(vs_low), 32'(VSW * HT));

    pattern_sel = 2'd1;
    wait_fs("ramp_fs", FRAME + 100, n);
    chk("ramp_x0", 32'({r, g, b}), 32'h000000);
    repeat (10) @(negedge clk);
    chk("ramp_x10", 32'({r, g, b}), 32'h282828);

    pattern_sel = 2'd3;
    wait_fs("fb_fs", FRAME + 100, n);
    chk("pat3_px_0_0", 32'({r, g, b}), 32'h000000);
    repeat (6 * HT + 10) @(negedge clk);
`ifdef VIDEO_PATTERN_GEN_FB_EN
    chk("pat3_px_10_6", 32'({r, g, b}), 32'hFFFFFF);
`else
    chk("pat3_px_10_6", 32'({r, g, b}), 32'h000000);
`endif
    repeat (2) @(negedge clk);
    chk("pat3_px_12_6", 32'({r, g, b}), 32'h000000);

    for (int i = 0; i < 8; i++) begin
      pattern_sel = 2'($urandom_range(0, 3));
      repeat ($urandom_range(200, 3000)) @(negedge clk);
      if ($urandom_range(0, 2) == 0) begin
        enable = 1'b0;
        repeat ($urandom_range(1, 6)) @(negedge clk);
        enable = 1'b1;
      end
    end

    pattern_sel = 2'd0;
    wait_fs("pre_disable_fs", FRAME + 100, n);
    repeat (30) @(negedge clk);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("disable_drain");
    repeat (3) @(negedge clk);
    enable = 1'b1;
    wait_fs("reenable_fs", 10, n);
    chk("reenable_fs_latency", 32'(n), 32'd2);

    repeat (1000) @(negedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 chk_reset_outputs("async_reset");
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b1;
    wait_fs("post_reset_fs", 10, n);
    chk("post_reset_fs_latency", 32'(n), 32'd2);
    wait_fs("post_reset_frame", FRAME + 100, n);
    chk("post_reset_frame_period", 32'(n), 32'(FRAME));

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
